// File: rtl/upsampling_pkg.sv
// Shared scope package for the 8-bit sample path: sample width and the
// interpolator state encoding.
package upsampling_pkg;

    localparam int SAMPLE_W = 8;

    // EMPTY: no previous sample held; PRIMED: previous sample held, idle;
    // EMIT: emitting the FACTOR interpolated beats of one group.
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_PRIMED = 2'd1,
        ST_EMIT   = 2'd2
    } state_e;

endpackage : upsampling_pkg

// File: rtl/upsampling.sv
// Linear-interpolating upsampler: every accepted input sample produces
// 2^LOG2_FACTOR output beats stepping from the previous sample toward the
// current one. Ready/valid on both sides; stalls hold the output stable.
module upsampling
    import upsampling_pkg::*;
#(
    parameter int LOG2_FACTOR = 2
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [SAMPLE_W-1:0] iData,
    input  logic                iData_Valid,
    output logic                oReady,
    output logic [SAMPLE_W-1:0] oData,
    output logic                oData_Valid,
    input  logic                iReady
);

    // The accumulator holds the sample scaled by FACTOR, so the fractional
    // part of each step is kept and the output is a plain bit slice (floor).
    localparam int                     ACC_W  = SAMPLE_W + LOG2_FACTOR;
    localparam logic [LOG2_FACTOR-1:0] K_LAST = '1;

    state_e                     r_state;
    state_e                     w_state_next;
    logic [SAMPLE_W-1:0]        r_prev;
    logic [SAMPLE_W-1:0]        r_cur;
    logic signed [SAMPLE_W:0]   r_diff;
    logic [ACC_W-1:0]           r_acc;
    logic [LOG2_FACTOR-1:0]     r_k;

    logic                       w_ready;
    logic                       w_prime;
    logic                       w_load;
    logic                       w_step;
    logic                       w_end;
    logic [SAMPLE_W-1:0]        w_base;
    logic signed [SAMPLE_W:0]   w_diff_new;
    logic [ACC_W-1:0]           w_diff_ext;

    // The new group starts from w_base: prev when leaving PRIMED, cur when
    // chaining straight out of the last beat of the previous group.
    assign w_diff_new = $signed({1'b0, iData}) - $signed({1'b0, w_base});

    // Sign-extend the step to accumulator width; the sum wraps modulo 2^ACC_W
    // but the true result always lies between prev<<L and cur<<L.
    assign w_diff_ext = ACC_W'(r_diff);

    // State register.
    always_ff @(posedge iClk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge, independent of order.
        if (iRst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, input-ready and datapath control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_prime      = 1'b0;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_end        = 1'b0;
        w_base       = r_prev;

        case (r_state)
            ST_EMPTY: begin
                w_ready = 1'b1;
                if (iData_Valid) begin
                    w_prime      = 1'b1;
                    w_state_next = ST_PRIMED;
                end
            end
            ST_PRIMED: begin
                w_ready = 1'b1;
                if (iData_Valid) begin
                    w_load       = 1'b1;
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (iReady) begin
                    if (r_k == K_LAST) begin
                        // Last beat completing: the current sample becomes prev,
                        // and a simultaneous input chains the next group.
                        w_ready = 1'b1;
                        w_end   = 1'b1;
                        w_base  = r_cur;
                        if (iData_Valid) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_next = ST_PRIMED;
                        end
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase

        if (iRst) begin
            w_ready = 1'b0;
        end
    end

    // Sample, step and accumulator registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_prev <= '0;
            r_cur  <= '0;
            r_diff <= '0;
            r_acc  <= '0;
            r_k    <= '0;
        end else begin
            if (w_prime) begin
                r_prev <= iData;
            end
            if (w_end) begin
                r_prev <= r_cur;
            end
            if (w_load) begin
                r_cur  <= iData;
                r_diff <= w_diff_new;
                r_acc  <= ACC_W'(w_base) << LOG2_FACTOR;
                r_k    <= '0;
            end else if (w_step) begin
                r_acc  <= r_acc + w_diff_ext;
                r_k    <= r_k + 1'b1;
            end
        end
    end

    assign oData       = r_acc[ACC_W-1 -: SAMPLE_W];
    assign oData_Valid = (r_state == ST_EMIT);
    assign oReady      = w_ready;

endmodule : upsampling

// File: tb/tb_upsampling.sv
// Directed bench for the upsampler: a cycle-exact vector table on a
// FACTOR=4 instance, plus a sweep of FACTOR=2 and FACTOR=256 instances.
module tb_upsampling;

    typedef struct {
        bit       rst;
        bit       vin;
        bit [7:0] din;
        bit       rdy;
        bit       ev;
        bit [7:0] ed;
        bit       eo;
        bit       cd;
    } vec_t;

    logic       iClk;

    // FACTOR=4 instance
    logic       m_rst, m_vin, m_ordy, m_ovalid, m_rdy;
    logic [7:0] m_din, m_odata;

    // Sweep instances (shared stimulus)
    logic       s_rst, s_vin, s_rdy;
    logic [7:0] s_din;
    logic       a_ordy, a_ovalid, b_ordy, b_ovalid;
    logic [7:0] a_odata, b_odata;

    int n_checks = 0;
    int n_pass   = 0;

    upsampling #(.LOG2_FACTOR(2)) u_dut (
        .iClk(iClk), .iRst(m_rst), .iData(m_din), .iData_Valid(m_vin),
        .oReady(m_ordy), .oData(m_odata), .oData_Valid(m_ovalid), .iReady(m_rdy)
    );

    upsampling #(.LOG2_FACTOR(1)) u_l1 (
        .iClk(iClk), .iRst(s_rst), .iData(s_din), .iData_Valid(s_vin),
        .oReady(a_ordy), .oData(a_odata), .oData_Valid(a_ovalid), .iReady(s_rdy)
    );

    upsampling #(.LOG2_FACTOR(8)) u_l8 (
        .iClk(iClk), .iRst(s_rst), .iData(s_din), .iData_Valid(s_vin),
        .oReady(b_ordy), .oData(b_odata), .oData_Valid(b_ovalid), .iReady(s_rdy)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(bit rst, bit vin, int din, bit rdy,
                                bit ev, int ed, bit eo, bit cd);
        vec_t v;
        v.rst = rst; v.vin = vin; v.din = din[7:0]; v.rdy = rdy;
        v.ev  = ev;  v.ed  = ed[7:0]; v.eo = eo; v.cd = cd;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int cnt_a, cnt_b, last_a, last_b, exp_v;

        m_rst = 1'b1; m_vin = 1'b0; m_din = '0; m_rdy = 1'b1;
        s_rst = 1'b1; s_vin = 1'b0; s_din = '0; s_rdy = 1'b1;

        //                rst vin din  rdy ev  ed  eo cd
        // reset, prime 0, then 100 -> 0,25,50,75 ; then 200 -> 100..175
        vecs.push_back(mk(1, 0,   0,  1,  0,   0, 0, 1));
        vecs.push_back(mk(0, 1,   0,  1,  0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 100,  1,  0,   0, 1, 0));
        vecs.push_back(mk(0, 0,   0,  1,  1,   0, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  25, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  50, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  75, 1, 1));
        vecs.push_back(mk(0, 1, 200,  1,  0,   0, 1, 0));
        vecs.push_back(mk(0, 0,   0,  1,  1, 100, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1, 125, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1, 150, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1, 175, 1, 1));
        // descending 200 -> 0, then 201 chained on the last beat (floor)
        vecs.push_back(mk(0, 1,   0,  1,  0,   0, 1, 0));
        vecs.push_back(mk(0, 0,   0,  1,  1, 200, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1, 150, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1, 100, 0, 1));
        vecs.push_back(mk(0, 1, 201,  1,  1,  50, 1, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,   0, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  50, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1, 100, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1, 150, 1, 1));
        // backpressure: 201 -> 1, stall 3 cycles on beat 1, stall last beat
        vecs.push_back(mk(0, 1,   1,  1,  0,   0, 1, 0));
        vecs.push_back(mk(0, 0,   0,  1,  1, 201, 0, 1));
        vecs.push_back(mk(0, 0,   0,  0,  1, 151, 0, 1));
        vecs.push_back(mk(0, 0,   0,  0,  1, 151, 0, 1));
        vecs.push_back(mk(0, 0,   0,  0,  1, 151, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1, 151, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1, 101, 0, 1));
        vecs.push_back(mk(0, 1,   0,  0,  1,  51, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  51, 1, 1));
        // reset from PRIMED, then streaming 0,40,80 with valid held high
        vecs.push_back(mk(1, 0,   0,  1,  0,   0, 0, 0));
        vecs.push_back(mk(1, 0,   0,  1,  0,   0, 0, 1));
        vecs.push_back(mk(0, 1,   0,  1,  0,   0, 1, 0));
        vecs.push_back(mk(0, 1,  40,  1,  0,   0, 1, 0));
        vecs.push_back(mk(0, 1,  80,  1,  1,   0, 0, 1));
        vecs.push_back(mk(0, 1,  80,  1,  1,  10, 0, 1));
        vecs.push_back(mk(0, 1,  80,  1,  1,  20, 0, 1));
        vecs.push_back(mk(0, 1,  80,  1,  1,  30, 1, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  40, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  50, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  60, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  70, 1, 1));
        vecs.push_back(mk(0, 0,   0,  1,  0,   0, 1, 0));
        // reset mid-EMIT at beat 2; 60 only primes; 100 -> 60,70,80,90
        vecs.push_back(mk(0, 1, 120,  1,  0,   0, 1, 0));
        vecs.push_back(mk(0, 0,   0,  1,  1,  80, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  90, 0, 1));
        vecs.push_back(mk(1, 0,   0,  1,  1, 100, 0, 1));
        vecs.push_back(mk(0, 1,  60,  1,  0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 100,  1,  0,   0, 1, 0));
        vecs.push_back(mk(0, 0,   0,  1,  1,  60, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  70, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  80, 0, 1));
        vecs.push_back(mk(0, 0,   0,  1,  1,  90, 1, 1));
        vecs.push_back(mk(0, 0,   0,  1,  0,   0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge iClk);
            #1;
            m_rst = vecs[i].rst;
            m_vin = vecs[i].vin;
            m_din = vecs[i].din;
            m_rdy = vecs[i].rdy;
            @(negedge iClk);
            check($sformatf("row%0d oData_Valid", i), int'(m_ovalid), int'(vecs[i].ev));
            check($sformatf("row%0d oReady", i), int'(m_ordy), int'(vecs[i].eo));
            if (vecs[i].cd) begin
                check($sformatf("row%0d oData", i), int'(m_odata), int'(vecs[i].ed));
            end
        end

        // Sweep: prime 255 then 0 on FACTOR=2 and FACTOR=256 instances.
        @(posedge iClk);
        #1;
        s_rst = 1'b0; s_vin = 1'b1; s_din = 8'd255;
        @(negedge iClk);
        check("sweep prime oReady F2", int'(a_ordy), 1);
        check("sweep prime oReady F256", int'(b_ordy), 1);
        @(posedge iClk);
        #1;
        s_din = 8'd0;
        @(negedge iClk);
        check("sweep load oReady F2", int'(a_ordy), 1);
        check("sweep load oReady F256", int'(b_ordy), 1);
        @(posedge iClk);
        #1;
        s_vin = 1'b0;

        cnt_a = 0; cnt_b = 0; last_a = -1; last_b = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge iClk);
            if (a_ovalid) begin
                exp_v = ((255 * 2) - 255 * cnt_a) / 2;
                check($sformatf("F2 beat%0d", cnt_a), int'(a_odata), exp_v);
                last_a = a_odata;
                cnt_a++;
            end
            if (b_ovalid) begin
                exp_v = ((255 * 256) - 255 * cnt_b) / 256;
                if (exp_v != int'(b_odata) || cnt_b % 64 == 0) begin
                    check($sformatf("F256 beat%0d", cnt_b), int'(b_odata), exp_v);
                end
                last_b = b_odata;
                cnt_b++;
            end
            @(posedge iClk);
            #1;
        end
        @(negedge iClk);
        check("F2 beat count", cnt_a, 2);
        check("F256 beat count", cnt_b, 256);
        check("F2 final beat", last_a, 127);
        check("F256 final beat", last_b, 0);
        check("F2 oReady after group", int'(a_ordy), 1);
        check("F256 oReady after group", int'(b_ordy), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_upsampling
